mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage load/store unit directly downstream of the EXE-stage ALU.
- Consumes the ALU result as the effective address, plus the rt value as store data, plus the 8-bit memory op.
- Checks alignment and drives a one-outstanding-transaction SRAM-like data bus with separate address and data handshakes.
- Extends load data, and stalls the pipeline until the access completes.

Parameters:
- BYTE_ADDR, 1: 1 = data_addr carries the full byte address; 0 = data_addr[1:0] forced to 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset; rst synchronous, active-high; clock clk
- flush_except  in  1  exception flush; cancels the current MEM instruction
- pipe_hold  in  1  pipeline held by another stage; MEM instruction must not advance
- valid_i  in  1  MEM-stage instruction valid
- op_i  in  8  ALU op code; memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW
- addr_i  in  32  effective address (ALU y)
- wdata_i  in  32  store source (rt)
- data_req  out  1  bus request
- data_wr  out  1  1 = store
- data_size  out  2  0 = byte, 1 = half, 2 = word
- data_addr  out  32  bus address
- data_wstrb  out  4  byte strobes (stores only; 0 for loads)
- data_wdata  out  32  lane-replicated store data
- data_addr_ok  in  1  address accepted
- data_data_ok  in  1  read data valid / write done
- data_rdata  in  32  bus read data
- rdata_o  out  32  extended load result
- mem_stall  out  1  stall request to the hazard unit
- adel  out  1  load address error
- ades  out  1  store address error
- badvaddr  out  32  faulting address

Behaviour:
- Reset state:
  - FSM in IDLE; rdata_q = 0.
  - data_req = 0, mem_stall = 0, adel = 0, ades = 0, badvaddr = 0, rdata_o = 0.
- Definitions:
  - mem_op = valid_i and op_i is a memory op.
  - misalign:
    - LW/SW: addr_i[1:0] != 0.
    - LH/LHU/SH: addr_i[0] != 0.
  - adel = mem_op & load & misalign; ades = mem_op & store & misalign. Both are combinational.
  - badvaddr = addr_i when adel or ades is set, else 0.
  - A misaligned access issues no request and asserts no mem_stall.
- Strobes and store data:
  - SB: wstrb = 0001 << addr_i[1:0]; wdata = {4{wdata_i[7:0]}}.
  - SH: wstrb = addr_i[1] ? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
  - SW: wstrb = 1111; wdata = wdata_i.
- Load extension (applied to data_rdata on the data_ok cycle, then to rdata_q):
  - Select the byte by addr_i[1:0]; select the half by addr_i[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- FSM states: IDLE, ADDR, DATA, HOLD, CANCEL.
  - IDLE:
    - If mem_op & ~misalign & ~flush_except, then data_req = 1 and mem_stall = 1.
    - On data_addr_ok -> DATA; otherwise -> ADDR.
  - ADDR:
    - data_req = 1, mem_stall = 1.
    - data_addr_ok -> DATA.
    - flush_except without addr_ok -> IDLE; the request is dropped that cycle.
  - DATA:
    - data_req = 0.
    - mem_stall = 1 until the data_ok cycle; mem_stall = 0 in the data_ok cycle.
    - On data_ok, capture the extended data into rdata_q.
    - data_ok & pipe_hold -> HOLD; data_ok & ~pipe_hold -> IDLE.
    - flush_except before data_ok -> CANCEL.
    - A store already accepted still completes at the slave.
  - HOLD:
    - No request; mem_stall = 0; rdata_o = rdata_q.
    - ~pipe_hold -> IDLE.
    - flush_except -> IDLE.
  - CANCEL:
    - No request; returning data is discarded.
    - mem_stall = mem_op (a new memory instruction waits).
    - data_ok -> IDLE, after which a pending op issues from IDLE.
- Invariants:
  - Never more than one accepted-but-unreturned transaction.
  - addr_ok and data_ok in the same cycle are only legal in DATA. In ADDR, data_ok is ignored.
- data_addr:
  - BYTE_ADDR = 1: addr_i.
  - BYTE_ADDR = 0: {addr_i[31:2], 2'b00}.
- Reset mid-transaction:
  - The FSM returns to IDLE.
  - The bus is assumed reset together with this unit; no drain is performed.

Decomposition:
- Shared defines header, common with the ALU:
  - memory op codes (LB … SW);
  - size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
  - FSM state localparams.
- One sub-module: mem_load_ext, the combinational lane select plus sign/zero extension, reused by the debug/trace path.

Test Plan:
- LW at 0x00001004, addr_ok in cycle 1, data_ok 2 cycles later with 0xDEADBEEF:
  - rdata_o = 0xDEADBEEF;
  - mem_stall high for 3 cycles, low on the data_ok cycle.
- LB at 0x1003 with rdata 0x80FF1234 -> rdata_o = 0xFFFFFF80. The same access as LBU -> 0x00000080.
- SH at 0x2002 with wdata_i 0x0000ABCD -> data_wstrb = 1100, data_wdata = 0xABCDABCD, data_size = 1, data_wr = 1.
- LW at 0x3001 -> adel = 1, badvaddr = 0x3001, data_req = 0, mem_stall = 0.
- LH issued with addr_ok, then flush_except in DATA, then a new LW presented:
  - state goes to CANCEL and the stale data is discarded;
  - the LW request is issued only after the old data_ok.
- LW data_ok while pipe_hold = 1 for 2 cycles:
  - rdata_o holds the captured value in HOLD;
  - no second data_req; return to IDLE when pipe_hold drops.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Memory op codes and size encodings are common with the ALU decode.
package mem_access_unit_pkg;

    // Memory op codes carried on the 8-bit ALU op bus
    localparam logic [7:0] OP_LB  = 8'h20;
    localparam logic [7:0] OP_LBU = 8'h21;
    localparam logic [7:0] OP_LH  = 8'h22;
    localparam logic [7:0] OP_LHU = 8'h23;
    localparam logic [7:0] OP_LW  = 8'h24;
    localparam logic [7:0] OP_SB  = 8'h28;
    localparam logic [7:0] OP_SH  = 8'h29;
    localparam logic [7:0] OP_SW  = 8'h2A;

    // Bus transfer size encodings
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // Bus transaction FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_CANCEL
    } mem_state_e;

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane select plus sign/zero extension.
// Purely combinational so the debug/trace path can reuse it on any word.
module mem_load_ext
    import mem_access_unit_pkg::*;
(
    input  logic [7:0]  op_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ext_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Pick the addressed byte/half and extend it according to the load type
    always_comb begin
        case (addr_lo_i)
            2'd0:    byteSel = rdata_i[7:0];
            2'd1:    byteSel = rdata_i[15:8];
            2'd2:    byteSel = rdata_i[23:16];
            default: byteSel = rdata_i[31:24];
        endcase
        halfSel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            OP_LB:   ext_o = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  ext_o = {24'h000000, byteSel};
            OP_LH:   ext_o = {{16{halfSel[15]}}, halfSel};
            OP_LHU:  ext_o = {16'h0000, halfSel};
            default: ext_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: alignment check, one-outstanding SRAM-like
// bus access with separate address/data handshakes, load extension and
// pipeline stall generation.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter bit BYTE_ADDR = 1'b1
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_except,
    input  logic        pipe_hold,
    input  logic        valid_i,
    input  logic [7:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic [31:0] rdata_o,
    output logic        mem_stall,
    output logic        adel,
    output logic        ades,
    output logic [31:0] badvaddr
);

    mem_state_e  state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        isLoad, isStore, memOp, misalign, issueOk;
    logic [1:0]  opSize;
    logic [31:0] extData;

    // Classify the op and check natural alignment for its size
    always_comb begin
        isLoad   = 1'b0;
        isStore  = 1'b0;
        opSize   = SIZE_WORD;
        misalign = 1'b0;
        case (op_i)
            OP_LB, OP_LBU: begin isLoad = 1'b1;  opSize = SIZE_BYTE; end
            OP_LH, OP_LHU: begin isLoad = 1'b1;  opSize = SIZE_HALF; end
            OP_LW:         isLoad = 1'b1;
            OP_SB:         begin isStore = 1'b1; opSize = SIZE_BYTE; end
            OP_SH:         begin isStore = 1'b1; opSize = SIZE_HALF; end
            OP_SW:         isStore = 1'b1;
            default:       ;
        endcase
        case (opSize)
            SIZE_HALF: misalign = addr_i[0];
            SIZE_WORD: misalign = addr_i[1] | addr_i[0];
            default:   misalign = 1'b0;
        endcase
    end

    assign memOp    = valid_i & (isLoad | isStore);
    assign issueOk  = memOp & ~misalign & ~flush_except;
    assign adel     = memOp & isLoad & misalign;
    assign ades     = memOp & isStore & misalign;
    assign badvaddr = (adel | ades) ? addr_i : 32'h0000_0000;

    assign data_wr   = isStore;
    assign data_size = opSize;
    assign data_addr = BYTE_ADDR ? addr_i : {addr_i[31:2], 2'b00};

    // Byte strobes and lane-replicated store data
    always_comb begin
        data_wstrb = 4'b0000;
        data_wdata = wdata_i;
        case (op_i)
            OP_SB: begin
                data_wstrb = 4'b0001 << addr_i[1:0];
                data_wdata = {4{wdata_i[7:0]}};
            end
            OP_SH: begin
                data_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
                data_wdata = {2{wdata_i[15:0]}};
            end
            OP_SW:   data_wstrb = 4'b1111;
            default: ;
        endcase
    end

    mem_load_ext uLoadExt (
        .op_i      (op_i),
        .addr_lo_i (addr_i[1:0]),
        .rdata_i   (data_rdata),
        .ext_o     (extData)
    );

    // Next state, bus request and stall; stall drops in the data_ok cycle so
    // the pipeline advances on the same edge the data is captured
    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        data_req  = 1'b0;
        mem_stall = 1'b0;
        rdata_o   = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (issueOk) begin
                    data_req  = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = data_addr_ok ? ST_DATA : ST_ADDR;
                end
            end
            ST_ADDR: begin
                mem_stall = 1'b1;
                if (flush_except) begin
                    state_d = ST_IDLE;
                end else begin
                    data_req = 1'b1;
                    if (data_addr_ok) state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (data_data_ok) begin
                    rdata_d = extData;
                    rdata_o = extData;
                    state_d = (pipe_hold && !flush_except) ? ST_HOLD : ST_IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (flush_except) state_d = ST_CANCEL;
                end
            end
            ST_HOLD: begin
                if (!pipe_hold || flush_except) state_d = ST_IDLE;
            end
            ST_CANCEL: begin
                mem_stall = memOp;
                if (data_data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured load data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rdata_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan scenarios
// followed by randomized instruction streams against a behavioural model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_except = 1'b0, pipe_hold = 1'b0, valid_i = 1'b0;
    logic [7:0]  op_i = 8'h00;
    logic [31:0] addr_i = 32'h0, wdata_i = 32'h0, data_rdata = 32'h0;
    logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;

    logic        data_req, data_wr, mem_stall, adel, ades;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, rdata_o, badvaddr;
    logic [3:0]  data_wstrb;

    logic        data_req0, data_wr0, mem_stall0, adel0, ades0;
    logic [1:0]  data_size0;
    logic [31:0] data_addr0, data_wdata0, rdata_o0, badvaddr0;
    logic [3:0]  data_wstrb0;

    mem_access_unit #(.BYTE_ADDR(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_except(flush_except), .pipe_hold(pipe_hold),
        .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .rdata_o(rdata_o), .mem_stall(mem_stall),
        .adel(adel), .ades(ades), .badvaddr(badvaddr)
    );

    // Word-addressed variant sharing the same stimulus
    mem_access_unit #(.BYTE_ADDR(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_except(flush_except), .pipe_hold(pipe_hold),
        .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .data_req(data_req0), .data_wr(data_wr0), .data_size(data_size0),
        .data_addr(data_addr0), .data_wstrb(data_wstrb0), .data_wdata(data_wdata0),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata), .rdata_o(rdata_o0), .mem_stall(mem_stall0),
        .adel(adel0), .ades(ades0), .badvaddr(badvaddr0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectations published by the stimulus tasks
    logic        chkEn = 1'b0, expReq = 1'b0, expStall = 1'b0, chkRd = 1'b0;
    logic [31:0] expRd = 32'h0;

    // Observations used by the literal pins of the directed scenarios
    int          stallCnt = 0;
    logic [31:0] obsRd = 32'h0, obsWdata = 32'h0, obsBadv = 32'h0;
    logic [3:0]  obsWstrb = 4'h0;
    logic [1:0]  obsSize = 2'h0;
    logic        obsWr = 1'b0, obsAdel = 1'b0, obsReq = 1'b0, obsStall = 1'b0;

    // Cancel-tail instruction presented while stale data drains
    logic        tailValid = 1'b0;
    logic [7:0]  tailOp = 8'h00;
    logic [31:0] tailAddr = 32'h0;
    int          tailLat = 0;

    logic [7:0] OPS [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    logic eAdel, eAdes;

    // ---------------- behavioural model ----------------
    function automatic int nBytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit isLd(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic bit isSt(input logic [7:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic bit misal(input logic [7:0] op, input logic [31:0] a);
        int n = nBytes(op);
        return (n > 1) && ((a & 32'(n - 1)) != 32'h0);
    endfunction

    function automatic int laneOff(input logic [7:0] op, input logic [31:0] a);
        return int'(a[1:0]) & ~(nBytes(op) - 1);
    endfunction

    function automatic logic [31:0] extModel(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
        int n = nBytes(op);
        logic [31:0] mask, v;
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
        v = (rd >> (8 * laneOff(op, a))) & mask;
        if ((op == OP_LB || op == OP_LH) && v[8 * n - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] wstrbModel(input logic [7:0] op, input logic [31:0] a);
        logic [31:0] s;
        s = ((32'h1 << nBytes(op)) - 32'h1) << laneOff(op, a);
        return isSt(op) ? s[3:0] : 4'h0;
    endfunction

    function automatic logic [31:0] wdataModel(input logic [7:0] op, input logic [31:0] wd);
        case (nBytes(op))
            1:       return {24'h0, wd[7:0]} * 32'h0101_0101;
            2:       return {16'h0, wd[15:0]} * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [1:0] sizeModel(input logic [7:0] op);
        int n = nBytes(op);
        return (n == 4) ? 2'd2 : 2'(n - 1);
    endfunction

    // ---------------- checking ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Compare process: every enabled cycle, DUT outputs against the model
    always @(negedge clk) begin
        if (chkEn) begin
            eAdel = valid_i && isLd(op_i) && misal(op_i, addr_i);
            eAdes = valid_i && isSt(op_i) && misal(op_i, addr_i);
            checkOutput("data_req", 32'(data_req), 32'(expReq));
            checkOutput("mem_stall", 32'(mem_stall), 32'(expStall));
            checkOutput("adel", 32'(adel), 32'(eAdel));
            checkOutput("ades", 32'(ades), 32'(eAdes));
            checkOutput("badvaddr", badvaddr, (eAdel || eAdes) ? addr_i : 32'h0);
            checkOutput("word-mode data_req", 32'(data_req0), 32'(expReq));
            if (expReq) begin
                checkOutput("data_wr", 32'(data_wr), 32'(isSt(op_i)));
                checkOutput("data_size", 32'(data_size), 32'(sizeModel(op_i)));
                checkOutput("data_addr", data_addr, addr_i);
                checkOutput("word-mode data_addr", data_addr0, addr_i & 32'hFFFF_FFFC);
                checkOutput("data_wstrb", 32'(data_wstrb), 32'(wstrbModel(op_i, addr_i)));
                if (isSt(op_i))
                    checkOutput("data_wdata", data_wdata, wdataModel(op_i, wdata_i));
            end
            if (chkRd) checkOutput("rdata_o", rdata_o, expRd);
            if (mem_stall) stallCnt++;
            if (data_req) begin
                obsWstrb = data_wstrb; obsWdata = data_wdata;
                obsSize = data_size;   obsWr = data_wr;
            end
            if (chkRd) obsRd = rdata_o;
            if (adel || ades) begin
                obsAdel = adel; obsBadv = badvaddr; obsReq = data_req; obsStall = mem_stall;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic v, input logic [7:0] op, input logic [31:0] a,
                                 input logic [31:0] wd, input logic fl, input logic ph,
                                 input logic aok, input logic dok, input logic [31:0] rd,
                                 input logic eReq, input logic eStall, input logic eChk,
                                 input logic [31:0] eRd);
        valid_i = v; op_i = op; addr_i = a; wdata_i = wd;
        flush_except = fl; pipe_hold = ph;
        data_addr_ok = aok; data_data_ok = dok; data_rdata = rd;
        expReq = eReq; expStall = eStall; chkRd = eChk; expRd = eRd;
        @(posedge clk); #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic v = 1'($urandom_range(0, 1));
            applyStimulus(v, v ? 8'h01 : OPS[$urandom_range(0, 7)], $urandom, $urandom,
                          1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic cancelTail();
        logic tm = tailValid && (nBytes(tailOp) != 0);
        for (int r = 0; r <= tailLat; r++)
            applyStimulus(tailValid, tailOp, tailAddr, 32'h0, 1'b0, 1'b0, 1'b0,
                          r == tailLat, $urandom, 1'b0, tm, 1'b0, 32'h0);
    endtask

    // One memory instruction: request phase, data phase, optional hold
    task automatic runInstr(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input int addrLat, input int dataLat, input int holdN,
                            input int flushAt, input logic [31:0] rdv, input bit holdFlush);
        logic        ld = isLd(op);
        logic [31:0] er = extModel(op, a, rdv);
        stallCnt = 0; obsRd = 32'h0; obsAdel = 1'b0;
        if (misal(op, a)) begin
            applyStimulus(1'b1, op, a, wd, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                          1'b0, 1'b0, 1'b0, 32'h0);
            return;
        end
        for (int k = 0; k <= addrLat; k++) begin
            bit fl   = (flushAt == k);
            bit junk = (k > 0) && (k < addrLat) && ($urandom_range(0, 3) == 0);
            applyStimulus(1'b1, op, a, wd, fl, 1'b0, !fl && (k == addrLat), junk, $urandom,
                          !fl, (k > 0) || !fl, 1'b0, 32'h0);
            if (fl) return;
        end
        for (int j = 0; j < dataLat; j++) begin
            bit fl = (flushAt == addrLat + 1 + j);
            applyStimulus(1'b1, op, a, wd, fl, 1'b0, 1'b0, 1'b0, $urandom,
                          1'b0, 1'b1, 1'b0, 32'h0);
            if (fl) begin
                cancelTail();
                return;
            end
        end
        applyStimulus(1'b1, op, a, wd, 1'b0, holdN >= 0, 1'b0, 1'b1, rdv,
                      1'b0, 1'b0, ld, er);
        if (holdN >= 0) begin
            for (int h = 0; h < holdN; h++)
                applyStimulus(1'b1, op, a, wd, 1'b0, 1'b1, 1'b0, 1'b0, $urandom,
                              1'b0, 1'b0, ld, er);
            applyStimulus(1'b1, op, a, wd, holdFlush, holdFlush, 1'b0, 1'b0, $urandom,
                          1'b0, 1'b0, ld, er);
        end
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] a;
        int          aLat, dLat, hN, fAt;

        // Reset
        for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
        rst = 1'b0;
        chkEn = 1'b1;
        checkOutput("reset rdata_o", rdata_o, 32'h0);
        checkOutput("reset data_req", 32'(data_req), 32'h0);
        checkOutput("reset mem_stall", 32'(mem_stall), 32'h0);
        checkOutput("reset badvaddr", badvaddr, 32'h0);
        idleCycles(2);

        // LW with addr_ok one cycle in, data_ok two cycles after that
        runInstr(OP_LW, 32'h0000_1004, 32'h0, 1, 1, -1, -1, 32'hDEAD_BEEF, 1'b0);
        checkOutput("LW rdata", obsRd, 32'hDEAD_BEEF);
        checkOutput("LW stall cycles", 32'(stallCnt), 32'd3);
        idleCycles(1);

        // Byte loads, signed and unsigned
        runInstr(OP_LB, 32'h0000_1003, 32'h0, 0, 2, -1, -1, 32'h80FF_1234, 1'b0);
        checkOutput("LB rdata", obsRd, 32'hFFFF_FF80);
        runInstr(OP_LBU, 32'h0000_1003, 32'h0, 2, 0, -1, -1, 32'h80FF_1234, 1'b0);
        checkOutput("LBU rdata", obsRd, 32'h0000_0080);

        // Upper-half store
        runInstr(OP_SH, 32'h0000_2002, 32'h0000_ABCD, 1, 1, -1, -1, 32'h0, 1'b0);
        checkOutput("SH wstrb", 32'(obsWstrb), 32'hC);
        checkOutput("SH wdata", obsWdata, 32'hABCD_ABCD);
        checkOutput("SH size", 32'(obsSize), 32'd1);
        checkOutput("SH wr", 32'(obsWr), 32'd1);

        // Misaligned word load
        runInstr(OP_LW, 32'h0000_3001, 32'h0, 0, 0, -1, -1, 32'h0, 1'b0);
        checkOutput("misaligned adel", 32'(obsAdel), 32'd1);
        checkOutput("misaligned badvaddr", obsBadv, 32'h0000_3001);
        checkOutput("misaligned data_req", 32'(obsReq), 32'd0);
        checkOutput("misaligned mem_stall", 32'(obsStall), 32'd0);
        idleCycles(1);

        // Flush while data is outstanding; a new LW waits for the stale data_ok
        tailValid = 1'b1; tailOp = OP_LW; tailAddr = 32'h0000_4000; tailLat = 2;
        runInstr(OP_LH, 32'h0000_1002, 32'h0, 0, 3, -1, 2, 32'h0, 1'b0);
        checkOutput("cancel stall cycles", 32'(stallCnt), 32'd6);
        runInstr(OP_LW, 32'h0000_4000, 32'h0, 0, 1, -1, -1, 32'h1234_5678, 1'b0);
        checkOutput("post-cancel LW rdata", obsRd, 32'h1234_5678);

        // data_ok under pipe_hold for two cycles
        runInstr(OP_LW, 32'h0000_5008, 32'h0, 1, 0, 1, -1, 32'hCAFE_F00D, 1'b0);
        checkOutput("hold rdata", obsRd, 32'hCAFE_F00D);
        idleCycles(1);

        // Reset in the middle of an outstanding access
        applyStimulus(1'b1, OP_LW, 32'h0000_6000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0,
                      1'b1, 1'b1, 1'b0, 32'h0);
        chkEn = 1'b0;
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        chkEn = 1'b1;
        checkOutput("mid-transaction reset rdata_o", rdata_o, 32'h0);
        runInstr(OP_LHU, 32'h0000_6002, 32'h0, 0, 1, -1, -1, 32'h8001_7FFF, 1'b0);
        checkOutput("post-reset LHU rdata", obsRd, 32'h0000_8001);

        // Randomized instruction stream
        for (int n = 0; n < 400; n++) begin
            op = OPS[$urandom_range(0, 7)];
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nBytes(op) - 1);
            aLat = int'($urandom_range(0, 3));
            dLat = int'($urandom_range(0, 3));
            hN   = int'($urandom_range(0, 3)) - 1;
            fAt  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, aLat + dLat)) : -1;
            tailValid = 1'($urandom_range(0, 1));
            tailOp    = ($urandom_range(0, 3) == 0) ? 8'h01 : OPS[$urandom_range(0, 7)];
            tailAddr  = $urandom;
            tailLat   = int'($urandom_range(0, 3));
            runInstr(op, a, $urandom, aLat, dLat, hN, fAt, $urandom, 1'($urandom_range(0, 1)));
            idleCycles(int'($urandom_range(0, 2)));
        end

        chkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
